// File: rtl/instr_trace_fifo.sv
// Instruction trace capture FIFO: samples {PC, instr} pairs while tracing, stops on the jal x0,0 halt idiom.
// Optional TRACE_TIMESTAMP_EN adds a free-running cycle stamp per entry and the rd_cycle output.
module instr_trace_fifo #(
    parameter int          DEPTH       = 16,
    parameter logic [31:0] HALT_INSTR  = 32'h0000006F,
    parameter int          HALT_REPEAT = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       trace_en,
    input  logic [31:0]                PC_I,
    input  logic [31:0]                Instr_I,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [31:0]                rd_pc,
    output logic [31:0]                rd_instr,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [15:0]                drop_cnt,
`ifdef TRACE_TIMESTAMP_EN
    output logic [31:0]                rd_cycle,
`endif
    output logic                       halted
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = $clog2(HALT_REPEAT + 1) + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        HALTED  = 2'd2
    } state_t;

    state_t state;

    logic [31:0]   mem_pc    [DEPTH];
    logic [31:0]   mem_instr [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic [31:0]   hold_pc;
    logic [31:0]   hold_instr;
    logic [31:0]   prev_pc;
    logic [31:0]   last_push_pc;
    logic          last_push_vld;
    logic [HW-1:0] halt_cnt;
    logic [HW-1:0] halt_next;

    logic is_halt;
    logic capturing;
    logic suppress;
    logic cand;
    logic full;
    logic pop;
    logic push;
    logic drop;
    logic halt_hit;

`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] cycle_cnt;
    logic [31:0] mem_cyc [DEPTH];
    logic [31:0] hold_cyc;
`endif

    // Capture is qualified by trace_en directly, so the enabling cycle is already sampled.
    assign is_halt   = (Instr_I == HALT_INSTR);
    assign capturing = trace_en && (state != HALTED);
    assign suppress  = is_halt && last_push_vld && (PC_I == last_push_pc);
    assign cand      = capturing && !suppress;
    assign full      = (count_q == CW'(DEPTH));
    assign pop       = rd_valid && rd_ready;
    assign push      = cand && (!full || pop);
    assign drop      = cand && full && !pop;

    always_comb begin
        halt_next = '0;
        if (capturing && is_halt) begin
            if ((halt_cnt != '0) && (PC_I == prev_pc))
                halt_next = halt_cnt + HW'(1);
            else
                halt_next = HW'(1);
        end
    end

    assign halt_hit = capturing && (halt_next == HW'(HALT_REPEAT));

    // Head is read straight from storage; when empty the last popped entry is held.
    assign count    = count_q;
    assign rd_valid = (count_q != '0);
    assign rd_pc    = rd_valid ? mem_pc[rd_ptr]    : hold_pc;
    assign rd_instr = rd_valid ? mem_instr[rd_ptr] : hold_instr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]    <= PC_I;
            mem_instr[wr_ptr] <= Instr_I;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            halted        <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count_q       <= '0;
            overflow      <= 1'b0;
            drop_cnt      <= '0;
            hold_pc       <= '0;
            hold_instr    <= '0;
            prev_pc       <= '0;
            last_push_pc  <= '0;
            last_push_vld <= 1'b0;
            halt_cnt      <= '0;
        end else begin
            prev_pc  <= PC_I;
            halt_cnt <= halt_next;

            if (push) begin
                wr_ptr        <= wr_ptr + AW'(1);
                last_push_pc  <= PC_I;
                last_push_vld <= 1'b1;
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + AW'(1);
                hold_pc    <= mem_pc[rd_ptr];
                hold_instr <= mem_instr[rd_ptr];
            end
            if (push && !pop)
                count_q <= count_q + CW'(1);
            else if (pop && !push)
                count_q <= count_q - CW'(1);

            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF)
                    drop_cnt <= drop_cnt + 16'd1;
            end

            case (state)
                IDLE: begin
                    if (halt_hit) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end else if (trace_en) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (halt_hit) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end else if (!trace_en) begin
                        state <= IDLE;
                    end
                end
                HALTED: begin
                    state  <= HALTED;
                    halted <= 1'b1;
                end
                default: begin
                    state  <= IDLE;
                    halted <= 1'b0;
                end
            endcase
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    always_ff @(posedge clk) begin
        if (push)
            mem_cyc[wr_ptr] <= cycle_cnt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt <= '0;
            hold_cyc  <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (pop)
                hold_cyc <= mem_cyc[rd_ptr];
        end
    end

    assign rd_cycle = rd_valid ? mem_cyc[rd_ptr] : hold_cyc;
`endif

endmodule

// File: tb/tb_instr_trace_fifo.sv
// Bench for instr_trace_fifo: random and directed capture traffic, checked against a queue-based model.
// Build with +define+TRACE_TIMESTAMP_EN to also check the per-entry cycle stamps.
module tb_instr_trace_fifo;

    localparam int          DEPTH       = 16;
    localparam logic [31:0] HALT        = 32'h0000006F;
    localparam int          HALT_REPEAT = 3;
    localparam logic [31:0] NOP         = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        trace_en = 1'b0;
    logic [31:0] PC_I = '0;
    logic [31:0] Instr_I = '0;
    logic        rd_ready = 1'b0;
    logic        rd_valid;
    logic [31:0] rd_pc;
    logic [31:0] rd_instr;
    logic [4:0]  count;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic        halted;
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] rd_cycle;
`endif

    int total = 0;
    int bad   = 0;

    // Scoreboard: expected entries {pc, instr} and their stamps, in push order.
    logic [63:0] exp_q[$];
    logic [31:0] exp_ts_q[$];
    logic [63:0] m_hold;
    logic [31:0] m_hold_ts;
    logic [31:0] m_prev_pc;
    logic [31:0] m_last_pc;
    logic        m_last_vld;
    int          m_run;
    logic        m_halted;
    logic        m_ovf;
    logic [15:0] m_drop;
    logic [31:0] m_ts;

    instr_trace_fifo #(
        .DEPTH(DEPTH),
        .HALT_INSTR(HALT),
        .HALT_REPEAT(HALT_REPEAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .trace_en(trace_en),
        .PC_I(PC_I),
        .Instr_I(Instr_I),
        .rd_valid(rd_valid),
        .rd_ready(rd_ready),
        .rd_pc(rd_pc),
        .rd_instr(rd_instr),
        .count(count),
        .overflow(overflow),
        .drop_cnt(drop_cnt),
`ifdef TRACE_TIMESTAMP_EN
        .rd_cycle(rd_cycle),
`endif
        .halted(halted)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        trace_en = 1'b0;
        rd_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic en, input logic [31:0] pc, input logic [31:0] instr, input logic rdy);
        trace_en = en;
        PC_I     = pc;
        Instr_I  = instr;
        rd_ready = rdy;
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        return {r[31:7], 7'b0110011};
    endfunction

    // ---------------- monitor + reference model ----------------
    // Evaluated at the falling edge: first compare outputs against the model's state,
    // then advance the model by what the coming rising edge must do.
    always @(negedge clk) begin
        int  pre_size;
        bit  popped;
        bit  capt;
        bit  is_h;
        if (reset) begin
            exp_q.delete();
            exp_ts_q.delete();
            m_hold = '0; m_hold_ts = '0; m_prev_pc = '0; m_last_pc = '0;
            m_last_vld = 0; m_run = 0; m_halted = 0; m_ovf = 0; m_drop = '0; m_ts = '0;
        end else begin
            pre_size = exp_q.size();
            popped = 0;
            chk("count", 64'(count), 64'(pre_size));
            chk("overflow", 64'(overflow), 64'(m_ovf));
            chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
            chk("halted", 64'(halted), 64'(m_halted));
            if (pre_size != 0) begin
                chk("rd_valid", 64'(rd_valid), 64'd1);
                chk("head", {rd_pc, rd_instr}, exp_q[0]);
`ifdef TRACE_TIMESTAMP_EN
                chk("head_cycle", 64'(rd_cycle), 64'(exp_ts_q[0]));
`endif
                if (rd_ready) begin
                    m_hold = exp_q.pop_front();
                    m_hold_ts = exp_ts_q.pop_front();
                    popped = 1;
                end
            end else begin
                chk("rd_valid", 64'(rd_valid), 64'd0);
                chk("hold", {rd_pc, rd_instr}, m_hold);
`ifdef TRACE_TIMESTAMP_EN
                chk("hold_cycle", 64'(rd_cycle), 64'(m_hold_ts));
`endif
            end

            capt = trace_en && !m_halted;
            is_h = (Instr_I == HALT);
            if (capt) begin
                if (!(is_h && m_last_vld && PC_I == m_last_pc)) begin
                    if (pre_size < DEPTH || popped) begin
                        exp_q.push_back({PC_I, Instr_I});
                        exp_ts_q.push_back(m_ts);
                        m_last_pc = PC_I;
                        m_last_vld = 1;
                    end else begin
                        m_ovf = 1;
                        if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
                    end
                end
                if (is_h) m_run = (m_run > 0 && PC_I == m_prev_pc) ? m_run + 1 : 1;
                else      m_run = 0;
                if (m_run == HALT_REPEAT) m_halted = 1;
            end else begin
                m_run = 0;
            end
            m_prev_pc = PC_I;
            m_ts = m_ts + 32'd1;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] pc;
        int halt_len;
        int rdy_pct;
        int halted_for;

        do_reset();
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_valid", 64'(rd_valid), 64'd0);
        chk("reset_rd_pc", 64'(rd_pc), 64'd0);

        // Three captures without reading.
        step(1, 32'h0, NOP, 0);
        step(1, 32'h4, rand_instr(), 0);
        step(1, 32'h8, rand_instr(), 0);
        chk("t1_count", 64'(count), 64'd3);
        chk("t1_head_pc", 64'(rd_pc), 64'd0);
        chk("t1_head_instr", 64'(rd_instr), 64'(NOP));
        chk("t1_overflow", 64'(overflow), 64'd0);

        // Overfill by four, then drain in order.
        do_reset();
        for (int i = 0; i < 20; i++) step(1, 32'(4 * i), rand_instr(), 0);
        chk("t2_count", 64'(count), 64'd16);
        chk("t2_overflow", 64'(overflow), 64'd1);
        chk("t2_drop", 64'(drop_cnt), 64'd4);
        for (int i = 0; i < 16; i++) step(0, 32'h0, NOP, 1);
        chk("t2_drained", 64'(count), 64'd0);
        chk("t2_hold_pc", 64'(rd_pc), 64'd60);

        // Full with simultaneous pop and push.
        for (int i = 0; i < 16; i++) step(1, 32'h100 + 32'(4 * i), rand_instr(), 0);
        for (int i = 0; i < 5; i++) step(1, 32'h200 + 32'(4 * i), rand_instr(), 1);
        chk("t3_count", 64'(count), 64'd16);
        chk("t3_drop", 64'(drop_cnt), 64'd4);
        for (int i = 0; i < 16; i++) step(0, 32'h0, NOP, 1);

        // Halt idiom held on one PC.
        do_reset();
        step(1, 32'h20, HALT, 0);
        step(1, 32'h20, HALT, 0);
        chk("t4_not_yet", 64'(halted), 64'd0);
        step(1, 32'h20, HALT, 0);
        chk("t4_halted", 64'(halted), 64'd1);
        step(1, 32'h20, HALT, 0);
        step(1, 32'h20, HALT, 0);
        step(1, 32'h24, NOP, 0);
        chk("t4_count", 64'(count), 64'd1);
        chk("t4_entry", {rd_pc, rd_instr}, {32'h20, HALT});
        step(0, 32'h0, NOP, 1);
        chk("t4_read_ok", 64'(count), 64'd0);

        // Asynchronous reset in the middle of a cycle.
        do_reset();
        for (int i = 0; i < 7; i++) step(1, 32'h400 + 32'(4 * i), rand_instr(), 0);
        chk("t5_pre_count", 64'(count), 64'd7);
        #2 reset = 1'b1;
        #1;
        chk("t5_count", 64'(count), 64'd0);
        chk("t5_valid", 64'(rd_valid), 64'd0);
        chk("t5_halted", 64'(halted), 64'd0);
        chk("t5_overflow", 64'(overflow), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

`ifdef TRACE_TIMESTAMP_EN
        // Stamps: enable after five idle edges.
        do_reset();
        for (int i = 0; i < 5; i++) step(0, 32'h0, NOP, 0);
        step(1, 32'h800, rand_instr(), 0);
        step(1, 32'h804, rand_instr(), 0);
        chk("ts_first", 64'(rd_cycle), 64'd5);
        step(0, 32'h0, NOP, 1);
        chk("ts_second", 64'(rd_cycle), 64'd6);
`endif

        // Randomized traffic with varying read pressure, halt loops and resets.
        do_reset();
        pc = 32'h1000;
        rdy_pct = 50;
        halted_for = 0;
        for (int c = 0; c < 1500; c++) begin
            if (c % 100 == 0) rdy_pct = $urandom_range(0, 100);
            if (m_halted) halted_for++;
            if (halted_for > 25 || $urandom_range(0, 299) == 0) begin
                do_reset();
                halted_for = 0;
            end
            if ($urandom_range(0, 24) == 0) begin
                halt_len = $urandom_range(1, 5);
                for (int k = 0; k < halt_len; k++)
                    step(($urandom_range(0, 9) != 0), pc, HALT, ($urandom_range(0, 99) < rdy_pct));
            end else begin
                step(($urandom_range(0, 9) != 0), pc, rand_instr(), ($urandom_range(0, 99) < rdy_pct));
            end
            pc = ($urandom_range(0, 7) == 0) ? 32'($urandom) & 32'hFFFF_FFFC : pc + 32'd4;
        end
        for (int i = 0; i < 20; i++) step(0, 32'h0, NOP, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
